// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch-stage FSM state
// encodings, the canonical NOP word and the default reset PC. Also used by
// the control unit.
package cpu_defs;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'b00,
    NPC_JALR = 2'b01,
    NPC_BR   = 2'b10,
    NPC_JAL  = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } if_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_stage_npc.sv
// npc: combinational next-PC calculator.
//   pc      in  current PC
//   npc_op  in  next-PC select (seq / jalr / branch / jal)
//   br_take in  branch condition, consulted only for branches
//   imm     in  sign-extended immediate
//   alu_c   in  ALU result (rs1+imm for jalr)
//   target  out computed next PC (unchecked for alignment)
//   pc4     out pc + 4
// All arithmetic wraps modulo 2^32.
module npc
  import cpu_defs::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_take,
  input  logic [31:0] imm,
  input  logic [31:0] alu_c,
  output logic [31:0] target,
  output logic [31:0] pc4
);

  logic [31:0] pc_imm;

  assign pc4    = pc + 32'd4;
  assign pc_imm = pc + imm;

  always_comb begin
    target = pc4;
    case (npc_op_e'(npc_op))
      NPC_SEQ:  target = pc4;
      NPC_JALR: target = alu_c & ~32'h0000_0001;
      NPC_BR:   target = br_take ? pc_imm : pc4;
      NPC_JAL:  target = pc_imm;
      default:  target = pc4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a BOOT/FETCH/EXEC/HALT sequencer.
//   clk, rst              clock; asynchronous active-high reset
//   npc_op, br_take, imm, alu_c   next-PC inputs from decoder/ALU/sext
//   hold                  stall; freezes the instruction while in EXEC
//   imem_req/imem_addr    instruction-memory request and address (= pc)
//   imem_ready/imem_rdata memory response, accepted only in FETCH
//   inst/inst_valid       registered instruction to the decoder
//   pc/pc4                current PC and PC+4
//   misalign              sticky: a computed target was not word aligned
//   inst_cnt              retired instruction count (wraps)
module if_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  npc_op,
  input  logic        br_take,
  input  logic [31:0] imm,
  input  logic [31:0] alu_c,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        misalign,
  output logic [31:0] inst_cnt
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic [31:0] target;

  npc u_npc (
    .pc      (pc_q),
    .npc_op  (npc_op),
    .br_take (br_take),
    .imm     (imm),
    .alu_c   (alu_c),
    .target  (target),
    .pc4     (pc4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  // Request/valid are decoded from the state register so an asynchronous
  // reset drops imem_req in the same cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    cnt_d      = cnt_q;
    mis_d      = mis_q;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        inst_valid = 1'b1;
        if (!hold) begin
          if (target[1:0] == 2'b00) begin
            pc_d    = target;
            cnt_d   = cnt_q + 32'd1;
            state_d = ST_FETCH;
          end else begin
            mis_d   = 1'b1;
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign misalign  = mis_q;
  assign inst_cnt  = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  npc_op = 2'b00;
  logic        br_take = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] alu_c = '0;
  logic        hold = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misalign;
  logic [31:0] inst_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];

  logic [31:0] mpc;
  logic [31:0] mcnt;
  logic        mmis;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .npc_op     (npc_op),
    .br_take    (br_take),
    .imm        (imm),
    .alu_c      (alu_c),
    .hold       (hold),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc4        (pc4),
    .misalign   (misalign),
    .inst_cnt   (inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_target(input logic [31:0] p, input logic [1:0] op,
                                               input logic br, input logic [31:0] im,
                                               input logic [31:0] al);
    case (op)
      2'b00:   return p + 32'd4;
      2'b01:   return {al[31:1], 1'b0};
      2'b10:   return br ? (p + im) : (p + 32'd4);
      default: return p + im;
    endcase
  endfunction

  // Scoreboard side: accepted fetches and retiring instructions pop expectations.
  always @(negedge clk) begin
    if (!rst && imem_req && imem_ready) begin
      if (exp_addr_q.size() == 0) check("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
      else check("fetch_addr", imem_addr, exp_addr_q.pop_front());
    end
    if (!rst && inst_valid && !hold) begin
      if (exp_inst_q.size() == 0) check("unexpected_exec", inst, 32'hxxxx_xxxx);
      else check("exec_inst", inst, exp_inst_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    hold = 1'b0;
    step();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_pc4", pc4, RST_PC + 32'd4);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_mis", {31'b0, misalign}, 32'd0);
    check("rst_cnt", inst_cnt, 32'd0);
    exp_addr_q.delete();
    exp_inst_q.delete();
    mpc  = RST_PC;
    mcnt = '0;
    mmis = 1'b0;
    rst = 1'b0;
    step();  // BOOT cycle
    check("boot_req", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic run_inst(input logic [1:0] op, input logic br, input logic [31:0] im,
                          input logic [31:0] al, input logic [31:0] word,
                          input int unsigned hold_n, input int unsigned delay);
    logic [31:0] t;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) begin
      check("fetch_wait_timeout", 32'd0, 32'd1);
      return;
    end
    npc_op = op; br_take = br; imm = im; alu_c = al; hold = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    for (int unsigned d = 0; d < delay; d++) begin
      check("req_held", {31'b0, imem_req}, 32'd1);
      check("addr_stable", imem_addr, mpc);
      step();
    end
    exp_addr_q.push_back(mpc);
    exp_inst_q.push_back(word);
    imem_rdata = word;
    imem_ready = 1'b1;
    hold = (hold_n > 0);
    step();
    check("exec_valid", {31'b0, inst_valid}, 32'd1);
    check("exec_noreq", {31'b0, imem_req}, 32'd0);
    for (int unsigned h = 0; h < hold_n; h++) begin
      check("hold_pc", pc, mpc);
      check("hold_cnt", inst_cnt, mcnt);
      check("hold_inst", inst, word);
      check("hold_valid", {31'b0, inst_valid}, 32'd1);
      step();
    end
    hold = 1'b0;
    imem_ready = 1'b0;
    step();
    t = model_target(mpc, op, br, im, al);
    if (t[1:0] == 2'b00) begin
      mpc  = t;
      mcnt = mcnt + 32'd1;
    end else begin
      mmis = 1'b1;
    end
    check("pc", pc, mpc);
    check("cnt", inst_cnt, mcnt);
    check("misalign", {31'b0, misalign}, {31'b0, mmis});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Sequential fetch: addresses 0,4,8 then count of 3.
    for (int i = 0; i < 3; i++) run_inst(2'b00, 1'b0, '0, '0, 32'h0000_0013 + 32'(i) * 32'h100, 0, 0);
    check("cnt_after3", inst_cnt, 32'd3);
    // Jump to 0x100, then branch taken/not taken with imm = -8.
    run_inst(2'b11, 1'b0, 32'h100 - mpc, '0, 32'h1111_0001, 0, 0);
    check("jal_pc", pc, 32'h0000_0100);
    run_inst(2'b10, 1'b1, 32'hFFFF_FFF8, '0, 32'h1111_0002, 0, 0);
    check("br_taken", pc, 32'h0000_00F8);
    run_inst(2'b11, 1'b0, 32'h0000_0008, '0, 32'h1111_0003, 0, 0);
    run_inst(2'b10, 1'b0, 32'hFFFF_FFF8, '0, 32'h1111_0004, 0, 0);
    check("br_not_taken", pc, 32'h0000_0104);
    // Stall for 5 EXEC cycles with imem_ready high (ignored outside FETCH).
    run_inst(2'b00, 1'b0, '0, '0, 32'h2222_0001, 5, 0);
    // Slow memory: ready after 3 waiting cycles.
    run_inst(2'b00, 1'b0, '0, '0, 32'h2222_0002, 0, 3);
    // jalr clears bit 0.
    run_inst(2'b01, 1'b0, '0, 32'h0000_0205, 32'h3333_0001, 0, 0);
    check("jalr_pc", pc, 32'h0000_0204);
    // Wrap of the PC at the top of the address space.
    run_inst(2'b11, 1'b0, 32'hFFFF_FFFC - mpc, '0, 32'h3333_0002, 0, 0);
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_pc4", pc4, 32'h0000_0000);
    run_inst(2'b00, 1'b0, '0, '0, 32'h3333_0003, 0, 0);
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_mis", {31'b0, misalign}, 32'd0);
    // Misaligned jalr target halts with pc unchanged.
    run_inst(2'b01, 1'b0, '0, 32'h0000_0203, 32'h4444_0001, 0, 0);
    check("halt_mis", {31'b0, misalign}, 32'd1);
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_req", {31'b0, imem_req}, 32'd0);
      check("halt_valid", {31'b0, inst_valid}, 32'd0);
      check("halt_pc", pc, 32'h0000_0000);
      check("halt_cnt", inst_cnt, mcnt);
    end
    imem_ready = 1'b0;
    // Reset asserted while waiting in FETCH.
    do_reset();
    run_inst(2'b00, 1'b0, '0, '0, 32'h5555_0001, 0, 0);
    step();
    step();
    check("wait_req", {31'b0, imem_req}, 32'd1);
    check("wait_addr", imem_addr, 32'h0000_0004);
    imem_rdata = 32'h6666_6666;
    rst = 1'b1;
    #1;
    check("async_rst_req", {31'b0, imem_req}, 32'd0);
    check("async_rst_pc", pc, RST_PC);
    imem_ready = 1'b1;
    step();
    check("rst_inst_discard", inst, 32'h0000_0013);
    imem_ready = 1'b0;
    do_reset();
    run_inst(2'b00, 1'b0, '0, '0, 32'h5555_0002, 0, 0);
    check("post_rst_pc", pc, 32'h0000_0004);
    check("post_rst_cnt", inst_cnt, 32'd1);
    check("sb_addr_empty", exp_addr_q.size(), 32'd0);
    check("sb_inst_empty", exp_inst_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
